psram_responder: RTL

- Synthesizable model of the PSRAM device side of the SPI/QPI link driven by the team's PSRAM controller.
- Decodes the reset, SPI-to-QPI, quad-read and quad-write command sequences, and services read/write bursts from a small internal byte array.
- Used as the loopback target in simulation and in on-board self-test builds on the Tang Nano 1k, in place of the external chip.

---
 rtl/psram_pkg.sv | 34 +++
 rtl/psram_byte_array.sv | 24 ++
 rtl/psram_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared command codes, counter type and FSM encoding for the PSRAM device-side responder.
package psram_pkg;

    localparam logic [7:0] CMD_RSTEN   = 8'h66;
    localparam logic [7:0] CMD_RST     = 8'h99;
    localparam logic [7:0] CMD_SPI2QPI = 8'h35;
    localparam logic [7:0] CMD_QPI2SPI = 8'hF5;
    localparam logic [7:0] CMD_READ    = 8'hEB;
    localparam logic [7:0] CMD_WRITE   = 8'h02;

    localparam int BYTE_W = 8;

    // Phase counter; the *_LAST values are the count on the final sampling edge of a phase.
    typedef logic [7:0] cnt_t;
    localparam cnt_t SPI_LAST  = 8'd7;
    localparam cnt_t QPI_LAST  = 8'd1;
    localparam cnt_t ADDR_LAST = 8'd5;

    typedef enum logic [2:0] {
        IDLE,
        CMD_SPI,
        CMD_QPI,
        ADDR,
        WAIT,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

    function automatic cnt_t cnt_inc(input cnt_t c);
        return c + 8'd1;
    endfunction

endpackage

// File: rtl/psram_byte_array.sv
// Byte-wide RAM with synchronous write and asynchronous read, 2^ADDR_BITS entries.
module psram_byte_array
    import psram_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [BYTE_W-1:0]    wdata,
    output logic [BYTE_W-1:0]    rdata
);

    logic [BYTE_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/psram_responder.sv
// Device side of the PSRAM SPI/QPI link: command decode, mode/reset tracking and
// read/write bursts against an internal byte array.
module psram_responder
    import psram_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int READ_WAIT = 6
) (
    input  logic       mem_clk,
    input  logic       rst,
    input  logic       mem_ce,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic       sio_oe,
    output logic       qpi_mode,
    output logic       rst_armed,
    output logic       busy
);

    localparam cnt_t WAIT_LAST = cnt_t'(READ_WAIT);

    state_t               state, state_next;
    cnt_t                 cnt, cnt_next;
    logic                 is_write, is_write_next;
    logic                 nib_sel, nib_sel_next;
    logic [3:0]           sio_out_next;
    logic                 sio_oe_next;
    logic                 qpi_next;
    logic                 armed_next;

    logic [7:0]           shreg, shreg_next;
    logic [23:0]          addr, addr_next;
    logic [ADDR_BITS-1:0] ptr, ptr_next;

    logic [7:0]           cmd_spi;
    logic [7:0]           cmd_qpi;
    logic [23:0]          addr_shift;

    logic                 mem_we;
    logic [BYTE_W-1:0]    mem_wdata;
    logic [BYTE_W-1:0]    mem_rdata;

    // Upper address nibble and the SPI shifter's top bit never feed logic.
    logic                 unused_bits;
    assign unused_bits = ^{addr[23:20], shreg[7]};

    assign cmd_spi    = {shreg[6:0], sio_in[0]};
    assign cmd_qpi    = {shreg[3:0], sio_in};
    assign addr_shift = {addr[19:0], sio_in};
    assign busy       = (state != IDLE);

    psram_byte_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (mem_clk),
        .we    (mem_we),
        .addr  (ptr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_write  <= 1'b0;
            nib_sel   <= 1'b0;
            sio_out   <= 4'h0;
            sio_oe    <= 1'b0;
            qpi_mode  <= 1'b0;
            rst_armed <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            is_write  <= is_write_next;
            nib_sel   <= nib_sel_next;
            sio_out   <= sio_out_next;
            sio_oe    <= sio_oe_next;
            qpi_mode  <= qpi_next;
            rst_armed <= armed_next;
        end
    end

    // Shift registers and pointer are always loaded before they are consumed.
    always_ff @(posedge mem_clk) begin
        shreg <= shreg_next;
        addr  <= addr_next;
        ptr   <= ptr_next;
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        is_write_next = is_write;
        nib_sel_next  = nib_sel;
        sio_out_next  = sio_out;
        sio_oe_next   = sio_oe;
        qpi_next      = qpi_mode;
        armed_next    = rst_armed;
        shreg_next    = shreg;
        addr_next     = addr;
        ptr_next      = ptr;
        mem_we        = 1'b0;
        mem_wdata     = {shreg[3:0], sio_in};

        if (mem_ce) begin
            // Deselect aborts any transaction, including a byte whose low nibble never arrived.
            state_next   = IDLE;
            cnt_next     = '0;
            nib_sel_next = 1'b0;
            sio_out_next = 4'h0;
            sio_oe_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = 8'd1;
                    if (qpi_mode) begin
                        shreg_next = {4'h0, sio_in};
                        state_next = CMD_QPI;
                    end else begin
                        shreg_next = {7'h00, sio_in[0]};
                        state_next = CMD_SPI;
                    end
                end

                CMD_SPI: begin
                    shreg_next = cmd_spi;
                    cnt_next   = cnt_inc(cnt);
                    if (cnt == SPI_LAST) begin
                        state_next = IGNORE;
                        cnt_next   = '0;
                        case (cmd_spi)
                            CMD_RSTEN:   armed_next = 1'b1;
                            CMD_RST:     armed_next = 1'b0;
                            CMD_SPI2QPI: begin
                                qpi_next   = 1'b1;
                                armed_next = 1'b0;
                            end
                            default:     armed_next = 1'b0;
                        endcase
                    end
                end

                CMD_QPI: begin
                    shreg_next = cmd_qpi;
                    cnt_next   = cnt_inc(cnt);
                    if (cnt == QPI_LAST) begin
                        state_next = IGNORE;
                        cnt_next   = '0;
                        armed_next = 1'b0;
                        case (cmd_qpi)
                            CMD_READ: begin
                                state_next    = ADDR;
                                is_write_next = 1'b0;
                            end
                            CMD_WRITE: begin
                                state_next    = ADDR;
                                is_write_next = 1'b1;
                            end
                            CMD_QPI2SPI: qpi_next = 1'b0;
                            CMD_RSTEN:   armed_next = 1'b1;
                            CMD_RST: begin
                                if (rst_armed) begin
                                    qpi_next = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ADDR: begin
                    addr_next = addr_shift;
                    cnt_next  = cnt_inc(cnt);
                    if (cnt == ADDR_LAST) begin
                        ptr_next     = addr_shift[ADDR_BITS-1:0];
                        cnt_next     = '0;
                        nib_sel_next = 1'b0;
                        state_next   = is_write ? WDATA : WAIT;
                    end
                end

                WAIT: begin
                    // The edge after READ_WAIT counted edges launches the first high nibble.
                    if (cnt == WAIT_LAST) begin
                        sio_out_next = mem_rdata[7:4];
                        sio_oe_next  = 1'b1;
                        nib_sel_next = 1'b1;
                        state_next   = RDATA;
                    end else begin
                        cnt_next = cnt_inc(cnt);
                    end
                end

                RDATA: begin
                    sio_oe_next = 1'b1;
                    if (nib_sel) begin
                        sio_out_next = mem_rdata[3:0];
                        ptr_next     = ptr + ADDR_BITS'(1);
                        nib_sel_next = 1'b0;
                    end else begin
                        sio_out_next = mem_rdata[7:4];
                        nib_sel_next = 1'b1;
                    end
                end

                WDATA: begin
                    if (nib_sel) begin
                        mem_we       = 1'b1;
                        ptr_next     = ptr + ADDR_BITS'(1);
                        nib_sel_next = 1'b0;
                    end else begin
                        shreg_next   = {4'h0, sio_in};
                        nib_sel_next = 1'b1;
                    end
                end

                IGNORE: ;

                default: state_next = IDLE;
            endcase
        end
    end

endmodule
